// File: rtl/seg_carry_adder.sv
// Multi-cycle add/sub of two WIDTH-bit operands, one SEG_W-bit segment per cycle,
// LSB segment first, with a registered inter-segment carry and valid/ready handshakes.
module seg_carry_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned NSEG  = WIDTH / SEG_W;
    localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}});

    if ((WIDTH % SEG_W) != 0) begin : g_bad_seg_w
        $error("seg_carry_adder: SEG_W must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    int unsigned        base;
    logic [SEG_W-1:0]   seg_a;
    logic [SEG_W-1:0]   seg_b;
    logic [SEG_W:0]     seg_res;
    logic [WIDTH-1:0]   nxt_sum;
    logic               c_msb;
    logic               last_seg;

    // Current segment slice, its sum, and the result with that segment merged in.
    always_comb begin
        base     = SEG_W * 32'(cnt);
        seg_a    = SEG_W'(a_r >> base);
        seg_b    = SEG_W'(b_r >> base);
        seg_res  = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_W+1)'(carry);
        nxt_sum  = (sum & ~(SEG_MASK << base)) | (WIDTH'(seg_res[SEG_W-1:0]) << base);
        // Carry into the MSB recovered from the MSB's own sum bit and operand bits.
        c_msb    = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ seg_res[SEG_W-1];
        last_seg = (cnt == CNT_W'(NSEG - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub | cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    sum   <= nxt_sum;
                    carry <= seg_res[SEG_W];
                    if (last_seg) begin
                        cout      <= seg_res[SEG_W];
                        overflow  <= c_msb ^ seg_res[SEG_W];
                        zero      <= (nxt_sum == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seg_carry_adder.md
Name: seg_carry_adder

Overview:
- Parametrised, multi-cycle successor to the fetch-path 64-bit adder. Adds or subtracts two WIDTH-bit operands one SEG_W-bit segment per cycle, LSB segment first, with a registered carry between segments.
- Used wherever a wide add need not finish in one cycle, e.g. PC+offset in the sequential core. Provides valid/ready handshakes, add/sub mode, carry-in, and carry/overflow/zero flags.

Parameters:
- WIDTH, 64: operand and result width in bits.
- SEG_W, 16: bits processed per cycle. Must divide WIDTH evenly; elaboration fails otherwise.
- NSEG, WIDTH/SEG_W: derived localparam, not overridable. Equals the number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B+cin; 1 = A-B.
- cin  input  1  carry-in; ignored when sub=1.
- flush  input  1  synchronous abort; returns the block to IDLE.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB (for sub, 1 means no borrow).
- overflow  output  1  signed overflow, computed as carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset: clock and reset are one clock, rst_n asynchronous active-low. While rst_n=0 the state is IDLE, and in_ready=0, out_valid=0, sum=0, cout=0, overflow=0, zero=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. Accept occurs on in_valid&&in_ready.
  - On accept: latch a; latch b, or ~b when sub=1; latch carry = sub ? 1 : cin; set segment counter=0; go to RUN.
  - RUN: each cycle, segment k (bits k*SEG_W +: SEG_W) = A_k + B_k + carry. Write the segment into sum and update the carry register. On k=NSEG-1, capture the carry into the MSB, set cout/overflow/zero, and go to DONE. Otherwise k increments.
  - DONE: out_valid=1. sum and flags stay stable until out_ready=1, at which point the block returns to IDLE.
- Latency: the accept edge is t. out_valid is first high after edge t+NSEG (4 cycles at the defaults). Throughput is one operation per NSEG+2 cycles minimum.
- Inputs are sampled only on the accept edge. a, b, sub and cin may change during RUN with no effect.
- in_ready is 0 in RUN and DONE. A new operation cannot be accepted in the same cycle as a result handoff.
- out_valid, once high, stays high until out_ready. The result must not change while out_valid=1 and out_ready=0.
- sum, cout, overflow and zero hold the last result in IDLE, so they are readable after the handoff. sum is undefined-free but partial during RUN; the bench must check it only when out_valid=1.
- flush=1 in any state: the next state is IDLE, the counter clears, out_valid drops on the next edge, and nothing is accepted that cycle. flush has priority over accept and over out_ready.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the in-flight operation is lost.
- NSEG=1 (SEG_W=WIDTH) is legal: exactly one RUN cycle.
- Overflow/zero: computed from the full WIDTH-bit result only. The counter has width clog2(NSEG), with a minimum of 1 bit.

Test Plan:
- Defaults, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> after 4 cycles: sum=0, cout=1, overflow=0, zero=1. Confirms carry ripples across all 4 segments.
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, overflow=1, cout=0.
- sub=1, a=5, b=7 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Then sub=1, a=7, b=7 -> sum=0, cout=1, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum and flags stable, in_ready=0 throughout. A single out_ready pulse -> IDLE next cycle with in_ready=1. Change a/b during RUN -> result unaffected.
- Abort: flush at RUN k=2 -> IDLE next cycle, no out_valid. Next op a=10, b=20, cin=1 -> sum=31. Repeat with rst_n dropped mid-RUN -> outputs zero asynchronously.
- Parameter sweep: WIDTH=32/SEG_W=8 and WIDTH=64/SEG_W=64 (NSEG=1), 1000 random add/sub ops each -> results match reference arithmetic; latency equals NSEG.
